// File: rtl/tt_mod_counter.sv
// ----------------------------------------------------------------------------
// tt_mod_counter
//   Parametrised modulo up/down counter with prescaler, synchronous
//   clear/load, wrap-or-saturate at the range ends and a registered
//   terminal-count pulse.
//   Optional capture register: define COUNTER_CAPTURE_EN to add cap_in/cap_val.
// ----------------------------------------------------------------------------
module tt_mod_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 256,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_CAPTURE_EN
  input  logic             cap_in,
  output logic [WIDTH-1:0] cap_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Prescaler only needs to hold 0..PRESCALE-1; keep at least one bit.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             at_end;

  // A step happens on the last enabled cycle of each prescaler period.
  assign tick   = en && (ps_q == PS_LAST);
  // Terminal value depends on the direction being counted.
  assign at_end = up_dn ? (count_q == MAX_C) : (count_q == '0);

  // Next-state logic: clear > load > step > hold.
  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
      ps_d    = '0;
    end else if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
      ps_d    = '0;
    end else begin
      if (en) begin
        ps_d = tick ? '0 : ps_q + PW'(1);
      end
      if (tick) begin
        // Pulses on every tick at the end, including saturated holds.
        tc_d = at_end;
        if (up_dn) begin
          if (!at_end) begin
            count_d = count_q + WIDTH'(1);
          end else if (SATURATE == 0) begin
            count_d = '0;
          end
        end else begin
          if (!at_end) begin
            count_d = count_q - WIDTH'(1);
          end else if (SATURATE == 0) begin
            count_d = MAX_C;
          end
        end
      end
    end
  end

  // Counter, prescaler and terminal-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_q;

  // Snapshot of the pre-update count, independent of clear/load/en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (cap_in) begin
      cap_q <= count_q;
    end
  end

  assign cap_val = cap_q;
`endif

endmodule
